axi_ddr_read_master: RTL and testbench
======================================

AXI_DDR_READ_MASTER -- requirements
Module: axi_ddr_read_master

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 40'h00_2000_0000, DDR base byte address of the burst (8-byte aligned).
REQ-002 SHALL have parameter BURST_LEN, default 16, beats per burst (legal range 1..256).
REQ-003 SHALL have parameter MASTER_ID, default 4'b0, driven on M_AXI_ARID.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit (see REQ-029).
REQ-005 ACLK  in  1  single clock, all logic rising-edge.
REQ-006 ARESETn  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle request to read one burst.
REQ-008 busy  out  1  high whenever state is not S_IDLE.
REQ-009 done  out  1  one-cycle pulse in S_FINISH.
REQ-010 err  out  1  sticky error flag, cleared on accepted start.
REQ-011 state  out  3  current FSM state encoding.
REQ-012 m_axis_tdata  out  64  read data beat toward consumer.
REQ-013 m_axis_tvalid / m_axis_tready / m_axis_tlast  out/in/out  1 each  output stream handshake; tlast marks final beat.
REQ-014 M_AXI_ARID 4, M_AXI_ARADDR 40, M_AXI_ARLEN 8, M_AXI_ARSIZE 3, M_AXI_ARBURST 2  out  read address fields.
REQ-015 M_AXI_ARVALID out 1, M_AXI_ARREADY in 1  read address handshake.
REQ-016 M_AXI_RID 4, M_AXI_RDATA 64, M_AXI_RRESP 2, M_AXI_RLAST 1, M_AXI_RUSER 1, M_AXI_RVALID 1  in  read data channel.
REQ-017 M_AXI_RREADY  out  1  read data accept.
REQ-018 M_AXI_ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER SHALL be constant 0/4'b0011/3'b000/4'h0/4'h0/0.

Function
REQ-019 AR fields SHALL be constant: ARADDR=TARGET_ADDR, ARLEN=BURST_LEN-1, ARSIZE=3'b011, ARBURST=2'b01 (INCR).
REQ-020 FSM states: S_IDLE=0, S_ADDR=1, S_DATA=2, S_DRAIN=3, S_FINISH=4; undefined codes SHALL go to S_IDLE.
REQ-021 S_IDLE -> S_ADDR on start; start in any other state SHALL be ignored.
REQ-022 S_ADDR: ARVALID=1, held stable until ARREADY; on ARVALID&ARREADY -> S_DATA next cycle.
REQ-023 S_DATA: RREADY = FIFO not full; beat accepted on RVALID&RREADY, written into 4-entry FIFO with last flag = (beat count == BURST_LEN-1).
REQ-024 10-bit beat counter cleared on start, increments per accepted beat; after BURST_LEN beats -> S_DRAIN.
REQ-025 RRESP != 2'b00, RID != MASTER_ID, or RLAST mismatching the counter's last flag SHALL set err; data still forwarded, beat count authoritative.
REQ-026 FIFO output drives m_axis_*; pop on tvalid&tready; tdata/tlast stable while tvalid&!tready; simultaneous push and pop when full SHALL NOT be allowed (RREADY low when full), when empty SHALL pass through with 1-cycle latency.
REQ-027 S_DRAIN -> S_FINISH when FIFO empty; S_FINISH asserts done one cycle -> S_IDLE.
REQ-028 RREADY SHALL be 0 outside S_DATA; ARVALID 0 outside S_ADDR.

Reset
REQ-029 On ARESETn low (asynchronous): state=S_IDLE, ARVALID=0, RREADY=0, tvalid=0, tlast=0, tdata=0, done=0, busy=0, err=0, FIFO pointers/count and beat counter=0; reset mid-burst SHALL discard FIFO contents.

Configuration
REQ-030 Macro RD_TIMEOUT_EN defined: counter clears on any AR/R handshake or state change, counts in S_ADDR/S_DATA; reaching TIMEOUT_CYCLES SHALL set err (FSM keeps waiting, AXI protocol not violated). Undefined: no counter, err only per REQ-025.

Verification
REQ-031 Reset, start, ARREADY=1 at once, 16 beats data 0..15 RRESP=0, tready=1 -> ARLEN=15, ARADDR=0x20000000, tdata 0..15, tlast on 15, done one cycle, err=0.
REQ-032 tready held 0 during burst -> RREADY drops after 4 beats; releasing tready drains all 16 beats in order, no loss/duplication.
REQ-033 Beat 5 with RRESP=2'b10 -> err=1 sticky through done; next start clears err.
REQ-034 start asserted in S_DATA -> ignored; exactly one AR handshake per burst.
REQ-035 ARESETn low after beat 7 -> all outputs at reset values immediately; new start runs a clean burst.
REQ-036 With RD_TIMEOUT_EN, ARREADY held 0 for 1100 cycles -> err=1 at cycle 1024, ARVALID still 1; without macro err stays 0.

Source files
------------

// File: rtl/axi_ddr_read_master.sv
// axi_ddr_read_master: reads one fixed INCR burst from DDR over AXI4 and streams the beats through a 4-deep FIFO.
// Optional watchdog: define RD_TIMEOUT_EN to flag err when an AR/R wait exceeds TIMEOUT_CYCLES.
module axi_ddr_read_master #(
  parameter logic [39:0] TARGET_ADDR    = 40'h00_2000_0000,
  parameter int          BURST_LEN      = 16,
  parameter logic [3:0]  MASTER_ID      = 4'b0,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [3:0]  M_AXI_ARID,
  output logic [39:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic        M_AXI_ARLOCK,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic [3:0]  M_AXI_ARQOS,
  output logic [3:0]  M_AXI_ARREGION,
  output logic        M_AXI_ARUSER,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [3:0]  M_AXI_RID,
  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RUSER,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  logic [2:0]  state_next;
  logic [64:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic [9:0]  beat_cnt;
  logic        full, push, pop, last_beat, start_acc, ar_hs, beat_bad, to_hit;
  logic        unused_ruser;
  assign M_AXI_ARID     = MASTER_ID;
  assign M_AXI_ARADDR   = TARGET_ADDR;
  assign M_AXI_ARLEN    = 8'(BURST_LEN - 1);
  assign M_AXI_ARSIZE   = 3'b011;
  assign M_AXI_ARBURST  = 2'b01;
  assign M_AXI_ARLOCK   = 1'b0;
  assign M_AXI_ARCACHE  = 4'b0011;
  assign M_AXI_ARPROT   = 3'b000;
  assign M_AXI_ARQOS    = 4'h0;
  assign M_AXI_ARREGION = 4'h0;
  assign M_AXI_ARUSER   = 1'b0;
  assign unused_ruser   = M_AXI_RUSER;
  assign full      = count == 3'd4;
  assign push      = M_AXI_RVALID & M_AXI_RREADY;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign ar_hs     = M_AXI_ARVALID & M_AXI_ARREADY;
  assign start_acc = (state == S_IDLE) & start;
  assign last_beat = beat_cnt == 10'(BURST_LEN - 1);
  assign beat_bad  = push & ((M_AXI_RRESP != 2'b00) | (M_AXI_RID != MASTER_ID) | (M_AXI_RLAST != last_beat));
  // State register
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) state <= S_IDLE;
    else state <= state_next;
  // Next-state logic; the beat counter, not RLAST, decides when the burst ends
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = start ? S_ADDR : S_IDLE;
      S_ADDR:   state_next = M_AXI_ARREADY ? S_DATA : S_ADDR;
      S_DATA:   state_next = (push && last_beat) ? S_DRAIN : S_DATA;
      S_DRAIN:  state_next = (count == 3'd0) ? S_FINISH : S_DRAIN;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end
  // State-decoded outputs; RREADY low when full so a full FIFO never sees push and pop together
  always_comb begin
    busy          = state != S_IDLE;
    done          = state == S_FINISH;
    M_AXI_ARVALID = state == S_ADDR;
    M_AXI_RREADY  = (state == S_DATA) & ~full;
    m_axis_tvalid = count != 3'd0;
    m_axis_tlast  = mem[rd_ptr][64];
    m_axis_tdata  = mem[rd_ptr][63:0];
  end
  // FIFO storage and pointers; reset flushes any beats of an interrupted burst
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= {last_beat, M_AXI_RDATA};
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  // Beat counter, restarted by each accepted start
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) beat_cnt <= '0;
    else if (start_acc) beat_cnt <= '0;
    else if (push) beat_cnt <= beat_cnt + 10'd1;
  // Sticky error flag, cleared only when a new burst is accepted
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) err <= 1'b0;
    else err <= start_acc ? 1'b0 : (err | beat_bad | to_hit);
`ifdef RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_clr, waiting;
  assign waiting = (state == S_ADDR) | (state == S_DATA);
  assign to_clr  = ar_hs | push | (state != state_next);
  assign to_hit  = to_cnt == TW'(TIMEOUT_CYCLES);
  // Watchdog: measures idle time inside one wait state, saturating at the limit
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) to_cnt <= '0;
    else if (to_clr) to_cnt <= '0;
    else if (waiting && !to_hit) to_cnt <= to_cnt + 1'b1;
`else
  logic        unused_ar_hs;
  logic [31:0] unused_timeout;
  assign to_hit         = 1'b0;
  assign unused_ar_hs   = ar_hs;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif
endmodule

// File: tb/tb_axi_ddr_read_master.sv
// tb_axi_ddr_read_master: directed bench for the single-burst AXI read master.
module tb_axi_ddr_read_master;
`ifdef RD_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif
  logic        ACLK = 0, ARESETn = 0, start = 0;
  logic        busy, done, err;
  logic [2:0]  state;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready = 0;
  logic [3:0]  arid, arcache, arqos, arregion;
  logic [39:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst;
  logic        arlock, aruser, arvalid, arready = 0;
  logic [3:0]  rid = 0;
  logic [63:0] rdata = 0;
  logic [1:0]  rresp = 0;
  logic        rlast = 0, rvalid = 0, rready;
  int n_checks = 0, n_errors = 0, n_ar = 0, n_done = 0;
  logic [63:0] got_d [$];
  logic        got_l [$];
  axi_ddr_read_master dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .busy(busy), .done(done), .err(err), .state(state),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_ARREGION(arregion), .M_AXI_ARUSER(aruser), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RUSER(1'b0),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );
  always #5 ACLK = ~ACLK;
  // Observe handshakes mid-cycle, where every signal is settled for the coming edge
  always @(negedge ACLK)
    if (ARESETn) begin
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
      end
      if (arvalid && arready) n_ar++;
      if (done) n_done++;
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1;
    @(posedge ACLK); #1;
    start = 0;
  endtask
  task automatic r_beat(input logic [63:0] d, input logic [1:0] resp, input logic [3:0] id, input logic last);
    int t = 0;
    rvalid = 1; rdata = d; rresp = resp; rid = id; rlast = last;
    @(negedge ACLK);
    while (!rready && t < 200) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= 200) chk("rready_timeout", 0, 1);
    @(posedge ACLK); #1;
    rvalid = 0; rlast = 0; rresp = 0; rid = 0;
  endtask
  // kind: 1 = SLVERR on bad_idx, 2 = wrong RID on bad_idx, 3 = RLAST toggled on bad_idx
  task automatic run_beats(input int base, input int n, input int bad_idx, input int kind);
    for (int i = 0; i < n; i++)
      r_beat(64'(base + i), (i == bad_idx && kind == 1) ? 2'b10 : 2'b00,
             (i == bad_idx && kind == 2) ? 4'h5 : 4'h0, (i == 15) ^ (i == bad_idx && kind == 3));
  endtask
  task automatic wait_idle();
    int t = 0;
    @(negedge ACLK);
    while (busy && t < 200) begin
      @(negedge ACLK);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 0, 1);
  endtask
  task automatic check_stream(input int base);
    chk("beat_count", 64'(got_d.size()), 16);
    for (int i = 0; i < got_d.size() && i < 16; i++) begin
      chk("tdata", got_d[i], 64'(base + i));
      chk("tlast", 64'(got_l[i]), 64'(i == 15));
    end
  endtask
  task automatic new_burst();
    got_d.delete();
    got_l.delete();
    n_ar = 0;
    n_done = 0;
  endtask
  initial begin
    #23;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_err_done", {err, done}, 0);
    chk("arlen", arlen, 15);
    chk("araddr", araddr, 40'h20000000);
    chk("ar_fixed", {arid, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser},
        {4'h0, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0, 1'b0});
    @(posedge ACLK); #1;
    ARESETn = 1;
    // Basic burst
    new_burst();
    arready = 1;
    m_axis_tready = 1;
    pulse_start();
    chk("busy_after_start", busy, 1);
    run_beats(0, 16, -1, 0);
    wait_idle();
    check_stream(0);
    chk("basic_done_cnt", n_done, 1);
    chk("basic_ar_cnt", n_ar, 1);
    chk("basic_err", err, 0);
    // Back-pressure: FIFO fills, RREADY drops, then everything drains in order
    new_burst();
    m_axis_tready = 0;
    pulse_start();
    fork
      run_beats(100, 16, -1, 0);
      begin
        repeat (12) @(negedge ACLK);
        chk("bp_rready", rready, 0);
        chk("bp_state", state, 2);
        chk("bp_hold_data", m_axis_tdata, 100);
        chk("bp_no_out", 64'(got_d.size()), 0);
        @(posedge ACLK); #1;
        m_axis_tready = 1;
      end
    join
    wait_idle();
    check_stream(100);
    chk("bp_done_cnt", n_done, 1);
    // SLVERR on beat 5: sticky through done
    new_burst();
    pulse_start();
    run_beats(200, 16, 5, 1);
    wait_idle();
    check_stream(200);
    chk("resp_err_sticky", err, 1);
    chk("resp_done_cnt", n_done, 1);
    // New start clears err; a second start in S_DATA is ignored
    new_burst();
    pulse_start();
    chk("err_cleared", err, 0);
    @(posedge ACLK); #1;
    chk("in_data", state, 2);
    pulse_start();
    chk("start_ignored", state, 2);
    run_beats(300, 16, -1, 0);
    wait_idle();
    check_stream(300);
    chk("single_ar", n_ar, 1);
    chk("clean_err", err, 0);
    // Wrong RID and early RLAST both flag err
    new_burst();
    pulse_start();
    run_beats(400, 16, 9, 2);
    wait_idle();
    chk("rid_err", err, 1);
    new_burst();
    pulse_start();
    run_beats(500, 16, 3, 3);
    wait_idle();
    check_stream(500);
    chk("rlast_err", err, 1);
    // Reset after beat 7 with data still buffered
    new_burst();
    m_axis_tready = 0;
    pulse_start();
    run_beats(600, 4, 2, 1);
    m_axis_tready = 1;
    run_beats(604, 4, -1, 0);
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    chk("pre_rst_err", err, 1);
    ARESETn = 0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_outs", {busy, done, err, arvalid, rready, m_axis_tvalid, m_axis_tlast}, 0);
    chk("mid_rst_tdata", m_axis_tdata, 0);
    @(posedge ACLK); #1;
    ARESETn = 1;
    new_burst();
    pulse_start();
    run_beats(700, 16, -1, 0);
    wait_idle();
    check_stream(700);
    chk("post_rst_err", err, 0);
    // Address channel stall; watchdog only in the RD_TIMEOUT_EN build
    new_burst();
    arready = 0;
    pulse_start();
    repeat (1100) @(posedge ACLK);
    #1;
    chk("stall_arvalid", arvalid, 1);
    chk("stall_state", state, 1);
    chk("stall_err", err, EXP_TO);
    arready = 1;
    run_beats(800, 16, -1, 0);
    wait_idle();
    check_stream(800);
    chk("stall_ar_cnt", n_ar, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
